// File: rtl/alu_unit_pipe.sv
// alu_unit_pipe: registered integer execution unit with an iterative multiplier.
//
// Single-cycle ops (add/sub/shifts/upper-immediate) produce a registered write-back
// pulse one cycle after acceptance. mul runs on an iterative shift-add engine that
// retires MUL_BPC multiplier bits per cycle, holding in_ready low while it iterates.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   in_valid/in_ready  issue handshake (in_ready depends on FSM state only)
//   ope, ds_val, dt_val, dd, imm   operation, operands, destination, immediate
//   flush              synchronous abort of an in-flight multiply; blocks issue
//   is_busy            multiplier iterating
//   out_valid, out_addr, out_val   write-back pulse, register (0 = no write), data
module alu_unit_pipe #(
  parameter int unsigned W       = 32,
  parameter int unsigned AW      = 6,
  parameter int unsigned MUL_BPC = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [5:0]    ope,
  input  logic [W-1:0]  ds_val,
  input  logic [W-1:0]  dt_val,
  input  logic [AW-1:0] dd,
  input  logic [15:0]   imm,
  input  logic          flush,
  output logic          is_busy,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [W-1:0]  out_val
);

  localparam int unsigned N  = W / MUL_BPC;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = $clog2(W);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  mplier_q, mplier_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [AW-1:0] mdd_q, mdd_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [W-1:0]  out_val_q, out_val_d;

  logic [W-1:0]  imm_ext, op_b, alu_res, pp_sum, acc_next;
  logic [SW-1:0] shamt;
  logic          accept, is_mul, no_write;

  assign in_ready  = (state_q == StIdle);
  assign is_busy   = (state_q == StMul);
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_val   = out_val_q;

  assign imm_ext  = {{(W - 16){imm[15]}}, imm};
  assign op_b     = ope[2] ? dt_val : imm_ext;
  assign shamt    = op_b[SW-1:0];
  // flush wins over acceptance
  assign accept   = in_valid & in_ready & ~flush;
  assign is_mul   = (ope == 6'b110100);
  assign no_write = (ope == 6'b000000) || (ope[1:0] != 2'b00);

  always_comb begin
    alu_res = '0;
    case (ope)
      6'b001100, 6'b001000: alu_res = ds_val + op_b;
      6'b010100:            alu_res = ds_val - op_b;
      6'b011100, 6'b011000: alu_res = ds_val << shamt;
      6'b100100, 6'b100000: alu_res = ds_val >> shamt;
      6'b101100, 6'b101000: alu_res = W'($signed(ds_val) >>> shamt);
      // imm lands in [31:16]; its sign bit fills everything above bit 31
      6'b110000:            alu_res = (imm_ext << 16) | W'(ds_val[15:0]);
      default:              alu_res = '0;
    endcase
  end

  // Partial products for the MUL_BPC low multiplier bits this cycle.
  always_comb begin
    pp_sum = '0;
    for (int j = 0; j < int'(MUL_BPC); j++) begin
      if (mplier_q[j]) pp_sum = pp_sum + (mcand_q << j);
    end
    acc_next = acc_q + pp_sum;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    mdd_d       = mdd_q;
    out_valid_d = 1'b0;
    out_addr_d  = out_addr_q;
    out_val_d   = out_val_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = StMul;
            cnt_d    = CW'(N);
            mcand_d  = ds_val;
            mplier_d = dt_val;
            acc_d    = '0;
            mdd_d    = dd;
          end else if (!no_write) begin
            out_valid_d = 1'b1;
            out_addr_d  = dd;
            out_val_d   = alu_res;
          end
        end
      end
      StMul: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << MUL_BPC;
          mplier_d = mplier_q >> MUL_BPC;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d     = StIdle;
            out_valid_d = 1'b1;
            out_addr_d  = mdd_q;
            out_val_d   = acc_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      mdd_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      mdd_q       <= mdd_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_val_q   <= out_val_d;
    end
  end

endmodule

// File: doc/alu_unit_pipe.md
Name: alu_unit_pipe

Overview:
- Parametrised, registered successor of the combinational integer execution unit.
- Same 6-bit ope encoding for add/sub/shift/upper-immediate ops, now with a 1-cycle registered result path.
- Adds an iterative multi-cycle multiplier with real busy/ready handshaking and a flush input.
- Sits in the execute stage between the issue logic and the register-file write-back port.

Parameters:
- W, 32, datapath width; legal values 32 or 64.
- AW, 6, destination register address width; address 0 means "no write".
- MUL_BPC, 2, multiplier bits retired per cycle; legal 1, 2, 4; must divide W.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; acceptance = in_valid & in_ready at a rising edge
- ope  in  6  opcode
- ds_val  in  W  source operand
- dt_val  in  W  second operand, used when ope[2]=1
- dd  in  AW  destination register
- imm  in  16  immediate
- flush  in  1  synchronous abort of any in-flight multiply
- is_busy  out  1  multiplier iterating
- out_valid  out  1  write-back pulse
- out_addr  out  AW  write-back register; 0 = no write
- out_val  out  W  write-back data

Behaviour:
- Reset (rstn low, async): state IDLE, in_ready=1, is_busy=0, out_valid=0, out_addr=0, out_val=0, multiplier registers 0.
- Operand B = ope[2] ? dt_val : sign-extended imm. Shift amount = B[log2(W)-1:0]. Arithmetic is modulo 2^W.
- Opcodes:
  - 001100/001000: add
  - 010100: sub
  - 011100/011000: sll
  - 100100/100000: srl
  - 101100/101000: sra (arithmetic)
  - 110000: upper-immediate. Result bits [15:0]=ds_val[15:0], [31:16]=imm, bits above 31 = imm[15].
  - 110100: mul, low W bits of ds_val*dt_val, unsigned (equal to signed low half).
- Other ope with ope[1:0]=00 and ope≠0: result 0 written to dd.
- ope=0 or ope[1:0]≠00: accepted, no output (out_valid stays 0).
- Single-cycle ops: accepted at edge T -> out_valid=1 in the cycle after T, with out_addr=dd and out_val=result. out_valid lasts exactly one cycle unless another op is accepted at T+1. Back-to-back issue is allowed every cycle.
- FSM IDLE/MUL:
  - IDLE -> MUL when mul is accepted. Counter loads N=W/MUL_BPC; multiplicand, multiplier and dd are latched.
  - In MUL: each edge adds MUL_BPC partial products and decrements the counter. is_busy=1, in_ready=0.
  - The edge at which the counter reaches 0 registers out_valid=1, out_addr=latched dd, out_val=product, and the FSM returns to IDLE. in_ready=1 in the following cycle.
  - Mul latency: accepted at edge T -> out_valid in the cycle after edge T+N.
- in_ready = (state==IDLE). Combinational from state only, never from in_valid.
- in_valid while in_ready=0: ignored. The issuer must hold the op.
- flush=1:
  - In MUL: at the next edge go to IDLE, suppress the pending result, out_valid=0.
  - In IDLE: accepts nothing that edge and forces out_valid=0 next cycle.
  - flush has priority over acceptance.
- Reset mid-multiply clears the FSM immediately; no result is produced.
- out_valid with out_addr=0 is legal; write-back treats it as no write.

Test Plan:
- Reset, W=32: add ds=5, imm=0xFFFF (ope 001000, dd=3) -> next cycle out_valid=1, addr=3, val=4; then sub ds=2, dt=7 (010100) -> val=0xFFFFFFFB.
- Shifts: sra ds=0x80000000, dt=33 (101100) -> val=0xC0000000 (amount 1). Upper-immediate ds=0x1234ABCD, imm=0xBEEF (110000) -> 0xBEEFABCD.
- mul 0xFFFFFFFF*3, MUL_BPC=2, dd=9 -> in_ready low 16 cycles, out_valid one cycle later, addr=9, val=0xFFFFFFFD. An add presented while busy is held, then issued; its result follows the mul.
- flush asserted mid-mul (cycle 5) -> no out_valid, in_ready=1 next cycle. rstn pulsed mid-mul -> all outputs 0 immediately.
- ope=000001 and ope=0 -> no out_valid. ope=111100 -> out_valid, addr=dd, val=0. Repeat add/mul checks with W=64, MUL_BPC=4 (mul latency 17 cycles).
